// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: FSM state encoding, stage-register layout, memory defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } state_t;

    localparam int WORD_BYTES        = 4;
    localparam int MEM_BYTES_DEFAULT = 1024;

    // Everything captured from upstream at accept, plus the misalignment verdict
    // so the write-back beat does not need to re-derive it.
    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] b;
        logic [4:0]  wreg;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic        misalign;
    } stage_t;

    // A word access is misaligned when the byte offset within the word is nonzero.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Upstream transaction bus and write-back beat of the MEM/WB stage.
// Latency: n/a (wiring only). Ports: in_valid/in_ready handshake, ALUOut, B, WriteRegIn, control bits;
// Backpressure: in_ready low stalls upstream. Outputs: wb_valid, WriteReg, WriteData, RegWriteOut, misalign_err.
interface mem_wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ALUOut;
    logic [31:0] B;
    logic [4:0]  WriteRegIn;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic        wb_valid;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWriteOut;
    logic        misalign_err;

    // Upstream / register-file side.
    modport master (
        output in_valid, ALUOut, B, WriteRegIn, MemRead, MemWrite, MemtoReg, RegWrite,
        input  in_ready, wb_valid, WriteReg, WriteData, RegWriteOut, misalign_err
    );

    // The stage itself.
    modport slave (
        input  in_valid, ALUOut, B, WriteRegIn, MemRead, MemWrite, MemtoReg, RegWrite,
        output in_ready, wb_valid, WriteReg, WriteData, RegWriteOut, misalign_err
    );
endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Byte-addressed data memory with big-endian 32-bit synchronous word read and write.
// Latency: read data registered on the edge where re is high; writes land on the edge where we is high.
// Backpressure: none; ports: clk, we, re, addr (word aligned), wdata, rdata_q.
module data_mem
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata_q
);

    // Contents start at zero and are deliberately untouched by stage reset.
    logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       rdata_d;

    // addr is word aligned, so OR-ing the byte offset never carries.
    assign a0 = addr;
    assign a1 = addr | ADDR_W'(1);
    assign a2 = addr | ADDR_W'(2);
    assign a3 = addr | ADDR_W'(3);

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = {mem[a0], mem[a1], mem[a2], mem[a3]};
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            mem[a0] <= wdata[31:24];
            mem[a1] <= wdata[23:16];
            mem[a2] <= wdata[15:8];
            mem[a3] <= wdata[7:0];
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: captures an ALU result, performs a big-endian word load/store, presents a one-cycle write-back beat.
// Latency: accept to wb_valid is 1 cycle for ALU ops and misaligned accesses, 2 cycles for aligned loads/stores.
// Backpressure: in_ready is low only in ACCESS; ports are CLK, RESET (sync, active high) and the slave bus.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic          CLK,
    input  logic          RESET,
    mem_wb_stage_if.slave bus
);

    state_t      state_q, state_d;
    stage_t      stg_q, stg_d;
    stage_t      new_stg;
    state_t      new_state;
    logic        accept;
    logic        mem_we, mem_re;
    logic [31:0] rdata_q;

    // Capture and classify whatever upstream presents this cycle.
    always_comb begin
        new_stg.alu_out    = bus.ALUOut;
        new_stg.b          = bus.B;
        new_stg.wreg       = bus.WriteRegIn;
        new_stg.mem_read   = bus.MemRead;
        new_stg.mem_write  = bus.MemWrite;
        new_stg.mem_to_reg = bus.MemtoReg;
        new_stg.reg_write  = bus.RegWrite;
        new_stg.misalign   = (bus.MemRead | bus.MemWrite) & is_misaligned(bus.ALUOut);
        new_state          = ((bus.MemRead | bus.MemWrite) && !new_stg.misalign) ? ACCESS : WB;
    end

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        accept  = bus.in_valid & (state_q != ACCESS);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = new_state;
                    stg_d   = new_stg;
                end
            end
            ACCESS: state_d = WB;
            WB: begin
                if (accept) begin
                    state_d = new_state;
                    stg_d   = new_stg;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            stg_q   <= '0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
        end
    end

    // Only aligned memory ops ever reach ACCESS; a reset on that edge suppresses the store.
    assign mem_we = (state_q == ACCESS) & stg_q.mem_write & ~RESET;
    assign mem_re = (state_q == ACCESS) & ~stg_q.mem_write & stg_q.mem_read;

    data_mem #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk     (CLK),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (stg_q.alu_out[ADDR_W-1:0]),
        .wdata   (stg_q.b),
        .rdata_q (rdata_q)
    );

    // Write-back mux; all sources are flops, and everything is held at zero outside WB.
    always_comb begin
        bus.in_ready     = (state_q != ACCESS);
        bus.wb_valid     = (state_q == WB);
        bus.WriteReg     = '0;
        bus.WriteData    = '0;
        bus.RegWriteOut  = 1'b0;
        bus.misalign_err = 1'b0;
        if (state_q == WB) begin
            bus.WriteReg     = stg_q.wreg;
            bus.misalign_err = stg_q.misalign;
            if (stg_q.misalign) begin
                bus.WriteData   = '0;
                bus.RegWriteOut = 1'b0;
            end else if (stg_q.mem_write) begin
                bus.WriteData   = stg_q.alu_out;
                bus.RegWriteOut = 1'b0;
            end else if (stg_q.mem_read) begin
                bus.WriteData   = stg_q.mem_to_reg ? rdata_q : stg_q.alu_out;
                bus.RegWriteOut = stg_q.reg_write;
            end else begin
                bus.WriteData   = stg_q.alu_out;
                bus.RegWriteOut = stg_q.reg_write;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected beats at accept, negedge monitor pops and compares.
// Latency: expected wb_valid negedge is derived per op class (1 or 2 cycles after accept).
// Backpressure: driver holds in_valid until in_ready is seen, bounded by a cycle budget.
module tb_mem_wb_stage;

    localparam int MB = 1024;

    typedef struct {
        logic [4:0]  wreg;
        logic [31:0] data;
        logic        chk_data;
        logic        rw;
        logic        mis;
        int          due;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    mem_wb_stage_if bus();

    mem_wb_stage u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad   = 0;
    int         neg_cnt = 0;
    exp_t       sb[$];
    logic [7:0] mdl [MB];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive one transaction, wait for acceptance, and queue the beat the stage should produce.
    task automatic send(input logic [31:0] alu, input logic [31:0] bd, input logic [4:0] wr,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        output logic rdy0);
        exp_t       e;
        logic [9:0] a;
        bit         got;
        int         lat;
        bus.ALUOut     = alu;
        bus.B          = bd;
        bus.WriteRegIn = wr;
        bus.MemRead    = mr;
        bus.MemWrite   = mw;
        bus.MemtoReg   = m2r;
        bus.RegWrite   = rw;
        bus.in_valid   = 1'b1;
        got  = 0;
        rdy0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 0) rdy0 = bus.in_ready;
            if (bus.in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check("ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        a          = alu[9:0];
        e.wreg     = wr;
        e.chk_data = 1'b1;
        e.mis      = (mr | mw) && (alu[1:0] != 2'b00);
        if (e.mis) begin
            e.data = 32'h0; e.rw = 1'b0; lat = 1;
        end else if (mw) begin
            mdl[a] = bd[31:24]; mdl[a + 10'd1] = bd[23:16];
            mdl[a + 10'd2] = bd[15:8]; mdl[a + 10'd3] = bd[7:0];
            e.data = alu; e.chk_data = 1'b0; e.rw = 1'b0; lat = 2;
        end else if (mr) begin
            e.data = m2r ? {mdl[a], mdl[a + 10'd1], mdl[a + 10'd2], mdl[a + 10'd3]} : alu;
            e.rw = rw; lat = 2;
        end else begin
            e.data = alu; e.rw = rw; lat = 1;
        end
        e.due = neg_cnt + lat;
        sb.push_back(e);
        #1;
    endtask

    // Monitor: every write-back beat must match the oldest queued expectation, on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            neg_cnt++;
            if (bus.wb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_wb", 32'(bus.wb_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("wb_latency", 32'(neg_cnt), 32'(e.due));
                    check("wb_reg", 32'(bus.WriteReg), 32'(e.wreg));
                    if (e.chk_data) check("wb_data", bus.WriteData, e.data);
                    check("wb_regwrite", 32'(bus.RegWriteOut), 32'(e.rw));
                    check("wb_misalign", 32'(bus.misalign_err), 32'(e.mis));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_wbv"},   32'(bus.wb_valid), 32'd0);
        check({tag, "_wreg"},  32'(bus.WriteReg), 32'd0);
        check({tag, "_wdata"}, bus.WriteData, 32'd0);
        check({tag, "_rw"},    32'(bus.RegWriteOut), 32'd0);
        check({tag, "_mis"},   32'(bus.misalign_err), 32'd0);
    endtask

    initial begin
        logic r0, r1, r2;
        for (int i = 0; i < MB; i++) mdl[i] = 8'h00;

        // Reset held with a valid ALU op present: reset must win.
        RESET          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.ALUOut     = 32'h0000_0099;
        bus.B          = 32'h0;
        bus.WriteRegIn = 5'd9;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("rst");
        @(posedge CLK);
        #1;
        RESET        = 1'b0;
        bus.in_valid = 1'b0;
        idle(2);

        // Basic ALU op.
        send(32'h0000_000D, 32'h0, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, r0);
        idle(2);

        // Store then load accepted in the store's WB cycle.
        send(32'h0000_0008, 32'h1122_3344, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, r0);
        send(32'h0000_0008, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, r0);
        idle(3);
        check("peek_mem8",  32'(u_dut.u_mem.mem[8]),  32'h11);
        check("peek_mem11", 32'(u_dut.u_mem.mem[11]), 32'h44);

        // Misaligned load and store: error pulse, no memory traffic.
        send(32'h0000_0006, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, r0);
        send(32'h0000_000E, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, r0);
        idle(2);
        check("mis_mem_4_7", {u_dut.u_mem.mem[4], u_dut.u_mem.mem[5], u_dut.u_mem.mem[6], u_dut.u_mem.mem[7]}, 32'h0);
        check("mis_mem_12_15", {u_dut.u_mem.mem[12], u_dut.u_mem.mem[13], u_dut.u_mem.mem[14], u_dut.u_mem.mem[15]}, 32'h0);

        // Address wrap, store-over-read priority, load with MemtoReg=0, WriteReg 0 passthrough.
        send(32'h0000_0404, 32'hCAFE_F00D, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, r0);
        send(32'h0000_0004, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, r0);
        send(32'h0000_0020, 32'hA5A5_5A5A, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, r0);
        send(32'h0000_0020, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, r0);
        send(32'h0000_0008, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, r0);
        send(32'h1234_5678, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, r0);
        idle(3);

        // Three back-to-back ALU ops, in_ready high at every handshake.
        send(32'h0000_0101, 32'h0, 5'd21, 1'b0, 1'b0, 1'b0, 1'b1, r0);
        send(32'h0000_0202, 32'h0, 5'd22, 1'b0, 1'b0, 1'b0, 1'b0, r1);
        send(32'h0000_0303, 32'h0, 5'd23, 1'b0, 1'b0, 1'b0, 1'b1, r2);
        check("b2b_ready", {29'd0, r0, r1, r2}, 32'h7);
        idle(3);

        // Reset during ACCESS aborts a store to 0x10.
        bus.ALUOut     = 32'h0000_0010;
        bus.B          = 32'hDEAD_BEEF;
        bus.WriteRegIn = 5'd8;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b1;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.in_valid   = 1'b1;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        @(negedge CLK);
        check("abort_in_access", 32'(bus.in_ready), 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_outputs("abort");
        idle(3);
        check("abort_mem", {u_dut.u_mem.mem[16], u_dut.u_mem.mem[17], u_dut.u_mem.mem[18], u_dut.u_mem.mem[19]}, 32'h0);
        send(32'h0000_0010, 32'h0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, r0);
        idle(4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
